// File: rtl/seq_add_ctrl_pkg.sv
// seq_add_ctrl_pkg: shared constants, FSM state type and index-width helper for the sliced adder
package seq_add_ctrl_pkg;
  localparam int SLICE_W = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_add_ctrl_slice.sv
// add_slice_3b: combinational 3-bit ripple-carry adder slice
module add_slice_3b
  import seq_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W:0] c;
  always_comb begin
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE_W];
  end
endmodule

// File: rtl/seq_add_ctrl.sv
// seq_add_ctrl: WIDTH-bit adder built by stepping one 3-bit slice across the operands, LSB group first
module seq_add_ctrl
  import seq_add_ctrl_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int NSLICE = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int IW = idx_w(NSLICE);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry, last, sc;
  logic [SLICE_W-1:0] sa, sb, ss;
  assign last = idx == IW'(NSLICE - 1);
  assign sa = a_r[int'(idx)*SLICE_W +: SLICE_W];
  assign sb = b_r[int'(idx)*SLICE_W +: SLICE_W];
  add_slice_3b u_slice (.a(sa), .b(sb), .cin(carry), .sum(ss), .cout(sc));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && in_valid)  ? RUN  :
              (state == RUN  && last)      ? DONE :
              (state == DONE && res_ready) ? IDLE : state;
  end
  always_comb begin
    in_ready  = state == IDLE;
    res_valid = state == DONE;
    busy      = state != IDLE;
  end
  // idx parks at the last slice instead of wrapping; the next request reloads it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_r   <= a;
      b_r   <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[int'(idx)*SLICE_W +: SLICE_W] <= ss;
      carry <= sc;
      if (last) cout <= sc;
      else idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_seq_add_ctrl.sv
// tb_seq_add_ctrl: scoreboarded random and directed checks of the sliced adder (WIDTH=12 and WIDTH=3)
module tb_seq_add_ctrl;
  logic clk = 0, rst = 1;
  logic in_valid = 0, cin = 0, res_ready = 0;
  logic [11:0] a = 0, b = 0;
  logic in_ready, res_valid, cout, busy;
  logic [11:0] sum;
  logic v3 = 0, c3 = 0, rr3 = 0;
  logic [2:0] a3 = 0, b3 = 0;
  logic rdy3, rv3, co3, busy3;
  logic [2:0] s3;
  int total = 0, bad = 0, pushed = 0;
  bit hs = 0;
  logic [12:0] q[$];

  seq_add_ctrl #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .res_valid(res_valid), .res_ready(res_ready), .sum(sum), .cout(cout), .busy(busy));
  seq_add_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .a(a3), .b(b3), .cin(c3),
    .res_valid(rv3), .res_ready(rr3), .sum(s3), .cout(co3), .busy(busy3));

  always #5 clk = ~clk;

  function automatic logic [12:0] model(input logic [11:0] x, input logic [11:0] y, input logic c);
    return 13'(x) + 13'(y) + 13'(c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && in_valid && in_ready) begin
      q.push_back(model(a, b, cin));
      pushed++;
      hs = 1;
    end

  always @(negedge clk)
    if (!rst) begin
      check("ready_valid_excl", 32'(in_ready && res_valid), 0);
      if (res_valid && res_ready) begin
        if (q.size() == 0) check("unexpected_result", 32'({cout, sum}), 32'hFFFF_FFFF);
        else check("result", 32'({cout, sum}), 32'(q.pop_front()));
      end
    end

  task automatic issue(input logic [11:0] x, input logic [11:0] y, input logic c);
    int n = 0;
    @(posedge clk); #1;
    a = x; b = y; cin = c; in_valid = 1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    check("req_accept", 32'(in_ready), 1);
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic wait_res();
    int n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 50);
    check("res_timeout", 32'(res_valid), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_c, n, cyc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_sum_cout", 32'({cout, sum}), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk) rst = 0;

    // WIDTH=3: single pass
    @(posedge clk); #1;
    a3 = 3'h7; b3 = 3'h1; c3 = 0; v3 = 1; rr3 = 1;
    @(negedge clk) check("w3_ready", 32'(rdy3), 1);
    @(posedge clk); #1 v3 = 0;
    @(negedge clk) check("w3_busy", 32'({busy3, rv3}), 32'b10);
    @(negedge clk) check("w3_result", 32'({rv3, co3, s3}), 32'b1_1_000);
    @(negedge clk) check("w3_valid_drop", 32'(rv3), 0);

    // latency and one-cycle result pulse
    @(posedge clk); #1 res_ready = 1;
    issue(12'h0FF, 12'h001, 0);
    @(negedge clk) check("lat_busy", 32'({busy, res_valid}), 32'b10);
    repeat (3) @(negedge clk) check("lat_not_yet", 32'(res_valid), 0);
    @(negedge clk) check("lat_edge4", 32'({res_valid, cout, sum}), {19'b0, 1'b1, 1'b0, 12'h100});
    @(negedge clk) check("lat_pulse", 32'({in_ready, res_valid}), 32'b10);

    issue(12'hFFF, 12'h000, 1);
    wait_res();
    check("carry_chain", 32'({cout, sum}), 32'h1000);

    // stall in DONE with a pending new request
    @(posedge clk); #1 res_ready = 0;
    issue(12'h800, 12'h800, 0);
    wait_res();
    #1 a = 12'h001; b = 12'h002; cin = 0; in_valid = 1;
    repeat (3) @(negedge clk) begin
      check("stall_ready", 32'(in_ready), 0);
      check("stall_hold", 32'({res_valid, cout, sum}), 32'h3000);
    end
    @(posedge clk); #1 res_ready = 1;
    @(negedge clk) check("stall_last_done", 32'(res_valid), 1);
    @(negedge clk) check("stall_idle", 32'({in_ready, res_valid}), 32'b10);
    @(negedge clk) check("stall_accept", 32'({busy, in_ready}), 32'b10);
    #1 in_valid = 0;
    wait_res();
    check("stall_new_sum", 32'({cout, sum}), 32'h003);

    // abort during the 2nd RUN cycle
    @(negedge clk);
    issue(12'h123, 12'h456, 0);
    @(posedge clk); #2 rst = 1;
    #1 check("abort_state", 32'({in_ready, res_valid, busy}), 32'b100);
    check("abort_sum", 32'({cout, sum}), 0);
    @(negedge clk) rst = 0;
    q.delete();
    repeat (6) @(negedge clk) check("abort_no_valid", 32'(res_valid), 0);
    issue(12'h123, 12'h456, 0);
    wait_res();
    check("after_abort", 32'({cout, sum}), 32'h579);

    // back-to-back throughput
    @(posedge clk); #1;
    res_ready = 1; hs = 0; in_valid = 1;
    a = 12'($urandom); b = 12'($urandom); cin = 1'($urandom);
    last_c = -1; n = 0; cyc = 0;
    while (n < 6 && cyc < 200) begin
      @(negedge clk);
      if (res_valid) begin
        if (last_c >= 0) check("period", 32'(cyc - last_c), 6);
        last_c = cyc; n++;
      end
      @(posedge clk); #1; cyc++;
      if (hs) begin hs = 0; a = 12'($urandom); b = 12'($urandom); cin = 1'($urandom); end
    end
    check("b2b_count", 32'(n), 6);
    in_valid = 0;
    repeat (10) @(posedge clk);

    // random traffic with stalls
    begin
      int target = pushed + 1000;
      hs = 0; cyc = 0;
      while (pushed < target && cyc < 40000) begin
        @(posedge clk); #1; cyc++;
        if (hs) begin hs = 0; in_valid = 0; end
        if (!in_valid) begin
          in_valid = ($urandom % 3) != 0;
          a = ($urandom % 8 == 0) ? 12'hFFF : 12'($urandom);
          b = ($urandom % 8 == 0) ? 12'hFFF : 12'($urandom);
          cin = 1'($urandom);
        end
        res_ready = ($urandom % 4) != 0;
      end
      check("rand_issued", 32'(pushed >= target), 1);
      in_valid = 0; res_ready = 1;
      cyc = 0;
      while (q.size() != 0 && cyc < 100) begin @(posedge clk); cyc++; end
      check("queue_drained", 32'(q.size()), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
